// File: rtl/uart_tx_engine.sv
// ============================================================================
//  Module   : uart_tx_engine
//  Purpose  : UART transmitter with TX FIFO, baud timing and framing
//             (start / data / optional parity / one or two stop bits).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_engine #(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_W     = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              uart_en,
    input  logic              tx_en,
    input  logic              parity_enable,
    input  logic              parity,
    input  logic              stop_bit,
    input  logic [15:0]       baud_rate,
    input  logic              tx_fifo_wr_en,
    input  logic [DATA_W-1:0] tx_fifo_data,
    output logic              tx,
    output logic              tx_fifo_full,
    output logic              tx_fifo_empty,
    output logic              busy
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_BIT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_empty;
    logic               r_full;
    logic               r_wr_en_d;

    // Frame state
    state_t             r_state;
    state_t             w_state_next;
    logic [DATA_W-1:0]  r_shift;
    logic [DATA_W-1:0]  w_shift_next;
    logic [c_BIT_W-1:0] r_bit_cnt;
    logic [c_BIT_W-1:0] w_bit_cnt_next;
    logic [15:0]        r_baud_cnt;
    logic [15:0]        r_baud_lat;
    logic               r_pe_lat;
    logic               r_sb_lat;
    logic               r_par_bit;
    logic               r_tx;
    logic               r_busy;
    logic               w_tx_next;
    logic               w_busy_next;

    logic               w_push;
    logic               w_push_ok;
    logic               w_pop;
    logic               w_bit_end;
    logic [DATA_W-1:0]  w_head;

    // Only the rising edge of the write strobe counts as a push.
    assign w_push    = tx_fifo_wr_en & ~r_wr_en_d;
    assign w_push_ok = w_push & (r_count != c_CNT_W'(FIFO_DEPTH));
    assign w_head    = r_mem[r_rd_ptr];
    assign w_bit_end = (r_baud_cnt == r_baud_lat);

    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= tx_fifo_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_empty   <= 1'b1;
            r_full    <= 1'b0;
            r_wr_en_d <= 1'b0;
        end else begin
            r_wr_en_d <= tx_fifo_wr_en;
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_empty <= (r_count == '0);
            r_full  <= (r_count == c_CNT_W'(FIFO_DEPTH));
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        w_pop          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (uart_en && tx_en && !r_empty) begin
                    w_pop          = 1'b1;
                    w_state_next   = S_START;
                    w_shift_next   = w_head;
                    w_bit_cnt_next = '0;
                end
            end
            S_START: begin
                if (w_bit_end) w_state_next = S_DATA;
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_shift_next = r_shift >> 1;
                    if (r_bit_cnt == c_BIT_W'(DATA_W - 1)) begin
                        w_bit_cnt_next = '0;
                        w_state_next   = r_pe_lat ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + c_BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) w_state_next = S_STOP;
            end
            S_STOP: begin
                // Bit counter marks the first of two stop periods.
                if (w_bit_end) begin
                    if (r_sb_lat && (r_bit_cnt == '0)) begin
                        w_bit_cnt_next = c_BIT_W'(1);
                    end else begin
                        w_bit_cnt_next = '0;
                        w_state_next   = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        if (!uart_en && (r_state != S_IDLE)) begin
            w_state_next   = S_IDLE;
            w_bit_cnt_next = '0;
        end

        // tx/busy are registered, so derive them from the state being entered.
        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shift_next[0];
            S_PARITY: w_tx_next = r_par_bit;
            default:  w_tx_next = 1'b1;
        endcase
        w_busy_next = (w_state_next != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_baud_cnt <= '0;
            r_baud_lat <= '0;
            r_pe_lat   <= 1'b0;
            r_sb_lat   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_tx      <= w_tx_next;
            r_busy    <= w_busy_next;
            if ((r_state == S_IDLE) || (w_state_next != r_state) || w_bit_end) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + 16'd1;
            end
            if (w_pop) begin
                r_baud_lat <= baud_rate;
                r_pe_lat   <= parity_enable;
                r_sb_lat   <= stop_bit;
                r_par_bit  <= (^w_head) ^ parity;
            end
        end
    end

    assign tx            = r_tx;
    assign busy          = r_busy;
    assign tx_fifo_empty = r_empty;
    assign tx_fifo_full  = r_full;

endmodule

`default_nettype wire
